// File: rtl/state_trace_fifo_if.sv
// Record stream from state_trace_fifo to its consumer.
// A record transfers on every rising clk edge where rec_valid && rec_ready. rec_data is stable while rec_valid=1 and not yet accepted.
interface state_trace_fifo_if #(
  parameter int TS_WIDTH = 16
);
  logic                  rec_valid;
  logic                  rec_ready;
  logic [TS_WIDTH+3:0]   rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/state_trace_fifo.sv
// Timestamps every change of the upstream 2-bit state code into a FWFT record FIFO.
// Optional STATE_TRACE_OVF_COUNT_EN adds the saturating ovf_count output.
module state_trace_fifo #(
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               state_code,
  input  logic                     clear,
  state_trace_fifo_if.master       rec,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef STATE_TRACE_OVF_COUNT_EN
  ,
  output logic [7:0]               ovf_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = TS_WIDTH + 4;
  localparam logic [TS_WIDTH-1:0] TS_ONE = 1;
  localparam logic [PW-1:0]       PTR_ONE = 1;

  logic [1:0]          last_code;
  logic [TS_WIDTH-1:0] ts;
  logic [RW-1:0]       mem [DEPTH];
  logic [RW-1:0]       head_q;
  logic [RW-1:0]       new_rec;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       rd_next;
  logic                empty;
  logic                full;
  logic                evt;
  logic                pop;
  logic                push;
  logic                drop;

  // clear outranks push, pop and drop, so all three are gated by it here.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    evt     = (state_code != last_code);
    pop     = !empty && rec.rec_ready && !clear;
    push    = evt && !clear && (!full || pop);
    drop    = evt && !clear && full && !pop;
    new_rec = {last_code, state_code, ts};
    rd_next = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= new_rec;
    end
  end

  // head_q mirrors the entry at the read pointer; it only changes when a new
  // head exists, so rec_data keeps its last value once the FIFO drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_code <= 2'b00;
      ts        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      head_q    <= '0;
      overflow  <= 1'b0;
    end else begin
      last_code <= state_code;
      ts        <= ts + TS_ONE;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        rd_ptr <= rd_next;
        if (drop) begin
          overflow <= 1'b1;
        end
        if (rd_next == wr_ptr) begin
          if (push) begin
            head_q <= new_rec;
          end
        end else begin
          head_q <= mem[rd_next[AW-1:0]];
        end
      end
    end
  end

`ifdef STATE_TRACE_OVF_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= 8'd0;
    end else if (clear) begin
      ovf_count <= 8'd0;
    end else if (drop && (ovf_count != 8'hFF)) begin
      ovf_count <= ovf_count + 8'd1;
    end
  end
`endif

  assign rec.rec_valid = !empty;
  assign rec.rec_data  = head_q;
  assign level         = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_state_trace_fifo.sv
// Directed bench for state_trace_fifo: expected records queued at stimulus time,
// popped and compared by a negedge monitor whenever a record is accepted.
module tb_state_trace_fifo;

  localparam int TS_W  = 4;
  localparam int DEPTH = 8;
  localparam int RW    = TS_W + 4;

  logic        clk;
  logic        reset;
  logic [1:0]  state_code;
  logic        clear;
  logic        rec_ready;
  logic [3:0]  level;
  logic        overflow;
  logic [7:0]  ovf_count;

  logic [RW-1:0] exp_q[$];
  logic [1:0]    prev_code;
  int            edge_n;
  int            chk_cnt;
  int            pass_cnt;

  state_trace_fifo_if #(.TS_WIDTH(TS_W)) rec_if ();
  assign rec_if.rec_ready = rec_ready;

  state_trace_fifo #(.TS_WIDTH(TS_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .state_code (state_code),
    .clear      (clear),
    .rec        (rec_if.master),
    .level      (level),
    .overflow   (overflow)
`ifdef STATE_TRACE_OVF_COUNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

`ifndef STATE_TRACE_OVF_COUNT_EN
  assign ovf_count = 8'd0;
`endif

  // clock / reset-relative edge counter (index of the next edge = its timestamp)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // one cycle of stimulus; store=0 marks an event the FIFO must not keep
  task automatic drive(input logic [1:0] code, input logic rdy, input logic clr, input logic store);
    logic [TS_W-1:0] ts_exp;
    ts_exp     = edge_n[TS_W-1:0];
    state_code = code;
    rec_ready  = rdy;
    clear      = clr;
    if (clr) exp_q.delete();
    else if (code != prev_code && store) exp_q.push_back({prev_code, code, ts_exp});
    prev_code = code;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] next_code(input logic [1:0] c);
    return (c == 2'b11) ? 2'b01 : c + 2'b01;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && rec_if.rec_valid && rec_ready) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_record: got %0h expected none", rec_if.rec_data);
      end else begin
        check("record", {24'd0, rec_if.rec_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    chk_cnt    = 0;
    pass_cnt   = 0;
    reset      = 1'b1;
    state_code = 2'b01;
    clear      = 1'b0;
    rec_ready  = 1'b0;
    prev_code  = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_valid", {31'd0, rec_if.rec_valid}, 32'd0);
    check("reset_level", {28'd0, level}, 32'd0);
    check("reset_overflow", {31'd0, overflow}, 32'd0);
    check("reset_data", {24'd0, rec_if.rec_data}, 32'd0);
    check("reset_ovf_count", {24'd0, ovf_count}, 32'd0);

    // first edge after release captures {00,01,ts 0}
    reset = 1'b0;
    exp_q.push_back(8'h10);
    prev_code = 2'b01;
    @(posedge clk);
    #1;
    check("first_valid", {31'd0, rec_if.rec_valid}, 32'd1);
    check("first_data", {24'd0, rec_if.rec_data}, 32'h10);
    check("first_level", {28'd0, level}, 32'd1);
    drive(2'b01, 1'b1, 1'b0, 1'b0);
    check("drain1_level", {28'd0, level}, 32'd0);

    // 01 -> 10 -> 11 with the consumer always ready
    repeat (2) drive(2'b01, 1'b1, 1'b0, 1'b0);
    drive(2'b10, 1'b1, 1'b0, 1'b1);
    check("seq_level_a", {28'd0, level}, 32'd1);
    repeat (3) drive(2'b10, 1'b1, 1'b0, 1'b0);
    drive(2'b11, 1'b1, 1'b0, 1'b1);
    repeat (2) drive(2'b11, 1'b1, 1'b0, 1'b0);
    check("seq_level_b", {28'd0, level}, 32'd0);

    // nine changes into an eight-deep FIFO: last one dropped
    for (int i = 0; i < 9; i++) drive(next_code(prev_code), 1'b0, 1'b0, i < 8);
    check("full_level", {28'd0, level}, 32'd8);
    check("full_overflow", {31'd0, overflow}, 32'd1);
`ifdef STATE_TRACE_OVF_COUNT_EN
    check("full_ovf_count", {24'd0, ovf_count}, 32'd1);
`endif
    repeat (8) drive(prev_code, 1'b1, 1'b0, 1'b0);
    check("drained_level", {28'd0, level}, 32'd0);
    check("overflow_sticky", {31'd0, overflow}, 32'd1);

    // refill, then clear while an event arrives at the full FIFO
    for (int i = 0; i < 8; i++) drive(next_code(prev_code), 1'b0, 1'b0, 1'b1);
    check("refill_level", {28'd0, level}, 32'd8);
    drive(next_code(prev_code), 1'b0, 1'b1, 1'b0);
    check("clear_level", {28'd0, level}, 32'd0);
    check("clear_overflow", {31'd0, overflow}, 32'd0);
    check("clear_valid", {31'd0, rec_if.rec_valid}, 32'd0);
`ifdef STATE_TRACE_OVF_COUNT_EN
    check("clear_ovf_count", {24'd0, ovf_count}, 32'd0);
`endif
    drive(prev_code, 1'b0, 1'b0, 1'b0);
    check("post_clear_level", {28'd0, level}, 32'd0);

    // full FIFO, event and pop in the same cycle
    for (int i = 0; i < 8; i++) drive(next_code(prev_code), 1'b0, 1'b0, 1'b1);
    drive(next_code(prev_code), 1'b1, 1'b0, 1'b1);
    check("pushpop_level", {28'd0, level}, 32'd8);
    check("pushpop_overflow", {31'd0, overflow}, 32'd0);
    repeat (8) drive(prev_code, 1'b1, 1'b0, 1'b0);
    check("pushpop_drained", {28'd0, level}, 32'd0);

    // an event every cycle with the consumer always ready
    for (int i = 0; i < 12; i++) drive(next_code(prev_code), 1'b1, 1'b0, 1'b1);
    check("stream_level", {28'd0, level}, 32'd1);
    check("stream_overflow", {31'd0, overflow}, 32'd0);
    drive(prev_code, 1'b1, 1'b0, 1'b0);
    check("stream_drained", {28'd0, level}, 32'd0);

    // asynchronous reset while records are held
    for (int i = 0; i < 3; i++) drive(next_code(prev_code), 1'b0, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_level", {28'd0, level}, 32'd0);
    check("async_valid", {31'd0, rec_if.rec_valid}, 32'd0);
    exp_q.delete();
    state_code = 2'b10;
    prev_code  = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(8'h20);
    prev_code = 2'b10;
    @(posedge clk);
    #1;
    check("rerun_data", {24'd0, rec_if.rec_data}, 32'h20);
    check("rerun_level", {28'd0, level}, 32'd1);
    drive(2'b10, 1'b1, 1'b0, 1'b0);
    drive(2'b10, 1'b0, 1'b0, 1'b0);

    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
